// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
//
// Control unit for a multicycle RV32I datapath (R, I-ALU, load, store,
// beq/bne). Every instruction passes through FETCH -> DECODE and then, by
// class, through EXEC, MEM and WB. The opcode and funct fields are captured
// at the end of DECODE, and all later states decode from that copy.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   inst_control opcode, inst[6:0]
//   inst_alu     {funct7, funct3}; funct7[5] is inst_alu[8]
//   zero_flag    ALU result == 0 (used combinationally in EXEC for branches)
//   ir_en        fetch strobe / instruction latch enable
//   pc_en        PC load enable
//   sel          PC source: 0 = PC+4, 1 = PC+imm
//   sel2         write-back source: 0 = ALU, 1 = data memory
//   regw         register-file write enable
//   alu_src      ALU operand 2: 0 = rd2, 1 = imm
//   memw, memr   data-memory write / read
//   alu_op       ALU operation code
//   illegal      one-cycle pulse when an unsupported instruction is skipped
//   retired_cnt  count of completed instructions, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       inst_control,
  input  logic [9:0]       inst_alu,
  input  logic             zero_flag,
  output logic             ir_en,
  output logic             pc_en,
  output logic             sel,
  output logic             sel2,
  output logic             regw,
  output logic             alu_src,
  output logic             memw,
  output logic             memr,
  output logic [3:0]       alu_op,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_cnt
);

  // Opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ALU operation codes
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [6:0] op_lat;
  logic [9:0] funct_lat;

  // Raw FSM outputs, before the reset gate
  logic       ir_en_fsm;
  logic       pc_en_fsm;
  logic       sel_fsm;
  logic       sel2_fsm;
  logic       regw_fsm;
  logic       alu_src_fsm;
  logic       memw_fsm;
  logic       memr_fsm;
  logic [3:0] alu_op_fsm;
  logic       illegal_fsm;

  // -------------------------------------------------------------------------
  // Legality check on the live instruction; used only in DECODE, before
  // the fields have been latched.
  // -------------------------------------------------------------------------
  logic legal_live;

  always_comb begin
    legal_live = 1'b0;
    case (inst_control)
      OP_R, OP_I, OP_LOAD, OP_STORE: legal_live = 1'b1;
      OP_BRANCH:                     legal_live = (inst_alu[2:1] == 2'b00); // beq/bne
      default:                       legal_live = 1'b0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Class decode on the latched copy
  // -------------------------------------------------------------------------
  logic       is_r;
  logic       is_i;
  logic       is_load;
  logic       is_store;
  logic       is_branch;
  logic       is_bne;
  logic       funct7_5;
  logic [2:0] funct3;
  logic       imm_src;
  logic [3:0] alu_exec;

  assign is_r      = (op_lat == OP_R);
  assign is_i      = (op_lat == OP_I);
  assign is_load   = (op_lat == OP_LOAD);
  assign is_store  = (op_lat == OP_STORE);
  assign is_branch = (op_lat == OP_BRANCH);
  assign funct3    = funct_lat[2:0];
  assign funct7_5  = funct_lat[8];
  assign is_bne    = funct3[0];
  assign imm_src   = is_i | is_load | is_store;

  // ALU code used in EXEC and held through WB. funct7[5] selects SUB only
  // for R-type (ADDI has immediate bits there), but selects SRA for both
  // R-type and I-type shifts, since SRAI encodes it the same way.
  always_comb begin
    alu_exec = ALU_ADD;
    if (is_load || is_store) begin
      alu_exec = ALU_ADD;
    end else if (is_branch) begin
      alu_exec = ALU_SUB;
    end else begin
      case (funct3)
        3'b000:  alu_exec = (is_r && funct7_5) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_exec = ALU_SLL;
        3'b010:  alu_exec = ALU_SLT;
        3'b011:  alu_exec = ALU_SLTU;
        3'b100:  alu_exec = ALU_XOR;
        3'b101:  alu_exec = funct7_5 ? ALU_SRA : ALU_SRL;
        3'b110:  alu_exec = ALU_OR;
        default: alu_exec = ALU_AND;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State register and instruction latch
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      op_lat    <= '0;
      funct_lat <= '0;
    end else begin
      state <= state_next;
      if (state == S_DECODE) begin
        op_lat    <= inst_control;
        funct_lat <= inst_alu;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next state and outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_next  = state;
    ir_en_fsm   = 1'b0;
    pc_en_fsm   = 1'b0;
    sel_fsm     = 1'b0;
    sel2_fsm    = 1'b0;
    regw_fsm    = 1'b0;
    alu_src_fsm = 1'b0;
    memw_fsm    = 1'b0;
    memr_fsm    = 1'b0;
    alu_op_fsm  = ALU_AND;
    illegal_fsm = 1'b0;

    case (state)
      S_FETCH: begin
        ir_en_fsm  = 1'b1;
        state_next = S_DECODE;
      end

      S_DECODE: begin
        if (!legal_live) begin
          // Skip the instruction: advance PC by 4 without retiring it.
          illegal_fsm = 1'b1;
          pc_en_fsm   = 1'b1;
          state_next  = S_FETCH;
        end else begin
          state_next  = S_EXEC;
        end
      end

      S_EXEC: begin
        alu_op_fsm  = alu_exec;
        alu_src_fsm = imm_src;
        if (is_branch) begin
          pc_en_fsm  = 1'b1;
          sel_fsm    = is_bne ? ~zero_flag : zero_flag;
          state_next = S_FETCH;
        end else if (is_load || is_store) begin
          state_next = S_MEM;
        end else begin
          state_next = S_WB;
        end
      end

      S_MEM: begin
        alu_src_fsm = 1'b1;
        alu_op_fsm  = ALU_ADD;
        if (is_load) begin
          memr_fsm   = 1'b1;
          state_next = S_WB;
        end else begin
          memw_fsm   = 1'b1;
          pc_en_fsm  = 1'b1;
          state_next = S_FETCH;
        end
      end

      S_WB: begin
        regw_fsm    = 1'b1;
        pc_en_fsm   = 1'b1;
        sel2_fsm    = is_load;
        alu_op_fsm  = alu_exec;
        alu_src_fsm = imm_src;
        state_next  = S_FETCH;
      end

      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  // Outputs are forced low while rst is high, so an in-flight regw/memw
  // is cut off in the same cycle reset arrives rather than at the next edge.
  assign ir_en   = ir_en_fsm   & ~rst;
  assign pc_en   = pc_en_fsm   & ~rst;
  assign sel     = sel_fsm     & ~rst;
  assign sel2    = sel2_fsm    & ~rst;
  assign regw    = regw_fsm    & ~rst;
  assign alu_src = alu_src_fsm & ~rst;
  assign memw    = memw_fsm    & ~rst;
  assign memr    = memr_fsm    & ~rst;
  assign alu_op  = rst ? 4'b0000 : alu_op_fsm;
  assign illegal = illegal_fsm & ~rst;

  // -------------------------------------------------------------------------
  // Retired-instruction counter: every PC update except an illegal skip
  // marks a completed instruction.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_cnt <= '0;
    end else if (pc_en && !illegal) begin
      retired_cnt <= retired_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_fsm
//
// Drives a table of instructions through the control FSM. For each cycle the
// expected output vector is pushed to a queue when the stimulus is applied,
// then popped and compared once the DUT outputs have settled. The counter is
// built 2 bits wide so that wrap-around is reached quickly.
// ---------------------------------------------------------------------------
module tb_multicycle_control_fsm;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [6:0]       inst_control;
  logic [9:0]       inst_alu;
  logic             zero_flag;
  logic             ir_en;
  logic             pc_en;
  logic             sel;
  logic             sel2;
  logic             regw;
  logic             alu_src;
  logic             memw;
  logic             memr;
  logic [3:0]       alu_op;
  logic             illegal;
  logic [CNT_W-1:0] retired_cnt;

  multicycle_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_control (inst_control),
    .inst_alu     (inst_alu),
    .zero_flag    (zero_flag),
    .ir_en        (ir_en),
    .pc_en        (pc_en),
    .sel          (sel),
    .sel2         (sel2),
    .regw         (regw),
    .alu_src      (alu_src),
    .memw         (memw),
    .memr         (memr),
    .alu_op       (alu_op),
    .illegal      (illegal),
    .retired_cnt  (retired_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ir_en;
    logic       pc_en;
    logic       sel;
    logic       sel2;
    logic       regw;
    logic       alu_src;
    logic       memw;
    logic       memr;
    logic [3:0] alu_op;
    logic       illegal;
  } outs_t;

  outs_t            exp_q[$];
  outs_t            obs;
  logic [CNT_W-1:0] model_cnt;
  int               n_tests = 0;
  int               n_fail  = 0;

  assign obs = '{ir_en, pc_en, sel, sel2, regw, alu_src, memw, memr, alu_op, illegal};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  // Reference behaviour, written as per-class cycle sequences.
  function automatic logic [3:0] ref_alu(input logic [6:0] op, input logic [9:0] f);
    logic [3:0] r;
    if (op == 7'b0000011 || op == 7'b0100011) r = 4'b0010;
    else if (op == 7'b1100011)                r = 4'b0110;
    else begin
      case (f[2:0])
        3'd0: r = (op == 7'b0110011 && f[8]) ? 4'b0110 : 4'b0010;
        3'd1: r = 4'b0100;
        3'd2: r = 4'b0111;
        3'd3: r = 4'b1001;
        3'd4: r = 4'b0011;
        3'd5: r = f[8] ? 4'b1000 : 4'b0101;
        3'd6: r = 4'b0001;
        default: r = 4'b0000;
      endcase
    end
    return r;
  endfunction

  // Class: 0 = R/I-ALU, 1 = load, 2 = store, 3 = branch, 4 = illegal
  function automatic int ref_class(input logic [6:0] op, input logic [9:0] f);
    if (op == 7'b0110011 || op == 7'b0010011) return 0;
    if (op == 7'b0000011) return 1;
    if (op == 7'b0100011) return 2;
    if (op == 7'b1100011 && (f[2:0] == 3'b000 || f[2:0] == 3'b001)) return 3;
    return 4;
  endfunction

  function automatic int ref_len(input int cls);
    case (cls)
      0: return 4;
      1: return 5;
      2: return 4;
      3: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic outs_t ref_step(input logic [6:0] op, input logic [9:0] f,
                                     input logic z, input int step);
    outs_t e;
    int    cls;
    logic  imm;
    e   = '0;
    cls = ref_class(op, f);
    imm = (op != 7'b0110011) && (cls != 3);
    if (step == 0) begin
      e.ir_en = 1'b1;
    end else if (step == 1) begin
      if (cls == 4) begin
        e.illegal = 1'b1;
        e.pc_en   = 1'b1;
      end
    end else if (step == 2) begin
      e.alu_op  = ref_alu(op, f);
      e.alu_src = imm;
      if (cls == 3) begin
        e.pc_en = 1'b1;
        e.sel   = f[0] ? !z : z;
      end
    end else if (step == 3) begin
      if (cls == 0) begin
        e.regw = 1'b1; e.pc_en = 1'b1;
        e.alu_op = ref_alu(op, f); e.alu_src = imm;
      end else begin
        e.alu_op = 4'b0010; e.alu_src = 1'b1;
        if (cls == 1) e.memr = 1'b1;
        else begin e.memw = 1'b1; e.pc_en = 1'b1; end
      end
    end else begin
      e.regw = 1'b1; e.pc_en = 1'b1; e.sel2 = 1'b1;
      e.alu_op = 4'b0010; e.alu_src = 1'b1;
    end
    return e;
  endfunction

  // Runs one instruction starting in FETCH (called just after a falling
  // edge). If rst_step >= 0, reset is asserted mid-cycle at that step.
  task automatic run_instr(input int idx, input logic [6:0] op, input logic [9:0] f,
                           input logic z, input int rst_step);
    int    len;
    outs_t e;
    len = ref_len(ref_class(op, f));
    inst_control = op;
    inst_alu     = f;
    zero_flag    = z;
    for (int s = 0; s < len; s++) begin
      exp_q.push_back(ref_step(op, f, z, s));
      #1;
      e = exp_q.pop_front();
      check($sformatf("i%0d_s%0d_outs", idx, s), 32'(obs), 32'(e));
      check($sformatf("i%0d_s%0d_cnt", idx, s), 32'(retired_cnt), 32'(model_cnt));
      if (s == rst_step) begin
        #1 rst = 1'b1;
        exp_q.push_back('0);
        #1;
        e = exp_q.pop_front();
        check($sformatf("i%0d_rst_outs", idx), 32'(obs), 32'(e));
        check($sformatf("i%0d_rst_memw", idx), 32'(memw), 32'(0));
        check($sformatf("i%0d_rst_cnt", idx), 32'(retired_cnt), 32'(0));
        model_cnt = '0;
        @(negedge clk);
        rst = 1'b0;
        $display("[TB] txn %0d op=%b f=%b z=%b reset at step %0d", idx, op, f, z, s);
        return;
      end
      if (e.pc_en && !e.illegal) model_cnt = model_cnt + 1'b1;
      @(negedge clk);
    end
    $display("[TB] txn %0d op=%b f=%b z=%b cycles=%0d cnt=%0d", idx, op, f, z, len, model_cnt);
  endtask

  localparam int N = 20;
  logic [6:0] t_op [N] = '{
    7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011, 7'b0010011,
    7'b0010011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
    7'b1100011, 7'b1100011, 7'b1100011, 7'b1111111, 7'b1100011,
    7'b0100011, 7'b0110011, 7'b0000011, 7'b0010011, 7'b0110011};
  logic [9:0] t_f [N] = '{
    10'b0100000_000, 10'b0000000_000, 10'b0100000_101, 10'b0000000_011, 10'b0100000_000,
    10'b0100000_101, 10'b0000000_110, 10'b0000000_010, 10'b0000000_010, 10'b0000000_000,
    10'b0000000_000, 10'b0000000_001, 10'b0000000_001, 10'b0000000_000, 10'b0000000_010,
    10'b0000000_010, 10'b0000000_111, 10'b0000000_010, 10'b0000000_100, 10'b0000000_001};
  logic t_z [N] = '{0, 1, 0, 0, 0,  0, 0, 0, 0, 1,  0, 0, 1, 0, 0,  0, 0, 0, 1, 0};
  int   t_rs [N] = '{-1, -1, -1, -1, -1,  -1, -1, -1, -1, -1,
                     -1, -1, -1, -1, -1,   3, -1, -1, -1, -1};

  initial begin
    outs_t e;
    rst          = 1'b1;
    inst_control = '0;
    inst_alu     = '0;
    zero_flag    = 1'b0;
    model_cnt    = '0;
    repeat (2) @(negedge clk);
    #1;
    exp_q.push_back('0);
    e = exp_q.pop_front();
    check("reset_outs", 32'(obs), 32'(e));
    check("reset_cnt", 32'(retired_cnt), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      run_instr(i, t_op[i], t_f[i], t_z[i], t_rs[i]);
    end
    #1;
    check("final_fetch_ir_en", 32'(ir_en), 32'(1));
    check("final_cnt", 32'(retired_cnt), 32'(model_cnt));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Control-side counterpart to the datapath. It consumes `inst_control`, `inst_alu` and `zero_flag`, and drives `sel`, `sel2`, `regw`, `alu_src`, `memw`, `memr` and `alu_op`.
- Each RV32I instruction is sequenced over several cycles by a state machine.
- It also generates the PC and instruction-latch enables, flags illegal instructions and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- inst_control  input  7  opcode, inst[6:0].
- inst_alu  input  10  {funct7, funct3}; funct7[5] is inst_alu[8].
- zero_flag  input  1  ALU result == 0.
- ir_en  output  1  latch instruction / fetch strobe.
- pc_en  output  1  PC load enable.
- sel  output  1  PC source: 0 = PC+4, 1 = PC+imm.
- sel2  output  1  write-back source: 0 = ALU, 1 = data memory.
- regw  output  1  register-file write enable.
- alu_src  output  1  ALU operand2: 0 = rd2, 1 = imm.
- memw  output  1  data-memory write.
- memr  output  1  data-memory read.
- alu_op  output  4  ALU operation code.
- illegal  output  1  one-cycle pulse on an unsupported instruction.
- retired_cnt  output  CNT_W  instructions completed.

Behaviour:
- Reset: asynchronous. State goes to FETCH; `retired_cnt` = 0; latched opcode/funct = 0. While `rst` is high, every output is 0.
- States: FETCH, DECODE, EXEC, MEM, WB. Encoding is free.
- FETCH:
  - `ir_en` = 1.
  - Next state is DECODE.
- DECODE:
  - Latches `inst_control` and `inst_alu` into internal registers. All later states use the latched copy.
  - Supported opcodes: 0110011 (R), 0010011 (I-ALU), 0000011 (load), 0100011 (store), 1100011 (branch; funct3 000 = beq, 001 = bne only).
  - Any other opcode or branch funct3: `illegal` = 1, `pc_en` = 1, `sel` = 0, next state FETCH. The instruction is skipped and not counted.
  - Otherwise next state is EXEC.
- EXEC:
  - `alu_op` is driven per the table below.
  - `alu_src` = 1 for I-ALU, load and store; 0 otherwise.
  - R and I-ALU go to WB. Load and store go to MEM.
  - Branch: `pc_en` = 1; `sel` = `zero_flag` for beq and `!zero_flag` for bne. This path is combinational from `zero_flag`. Next state is FETCH.
- MEM:
  - `alu_src` = 1 and `alu_op` = ADD are held.
  - Load: `memr` = 1, next state WB.
  - Store: `memw` = 1, `pc_en` = 1, `sel` = 0, next state FETCH.
- WB:
  - `regw` = 1 and `pc_en` = 1.
  - `sel2` = 1 for load, else 0.
  - `alu_op` and `alu_src` hold their EXEC values.
  - Next state is FETCH.
- Latency in cycles: R/I-ALU 4, load 5, store 4, branch 3, illegal 2.
- alu_op table:
  - ADD = 0010, SUB = 0110, AND = 0000, OR = 0001, XOR = 0011, SLL = 0100, SRL = 0101, SRA = 1000, SLT = 0111, SLTU = 1001.
  - funct3 decode: 000 → ADD (SUB only when R-type and funct7[5] = 1); 001 → SLL; 010 → SLT; 011 → SLTU; 100 → XOR; 101 → SRL (SRA if funct7[5] = 1); 110 → OR; 111 → AND.
  - Loads and stores use ADD; branches use SUB.
- Default values: outputs not listed for a state are 0. `alu_op` defaults to 0000.
- `retired_cnt`: increments by 1 in every cycle where `pc_en` = 1 and `illegal` = 0. It wraps modulo 2^CNT_W.
- Reset mid-instruction: returns to FETCH immediately. There is no partial write, because `regw` and `memw` drop asynchronously with `rst`.
- Exclusivity: `regw` and `memw` are never high in the same cycle. `memr` and `memw` are never high together.

Test Plan:
- Reset, then release → cycle 0 after release: state FETCH, `ir_en` = 1; all other outputs 0; `retired_cnt` = 0.
- R-type sub (opcode 0110011, `inst_alu` = 0100000_000) → `alu_op` = 0110 in EXEC/WB; `regw` = 1 and `pc_en` = 1 exactly on cycle 4; `sel2` = 0; `retired_cnt` = 1.
- Load (0000011) → `alu_src` = 1 and `alu_op` = 0010; `memr` = 1 on cycle 4; `regw` = 1 and `sel2` = 1 on cycle 5; `pc_en` only on cycle 5.
- beq with `zero_flag` = 1 → cycle 3: `sel` = 1, `pc_en` = 1. Repeat with `zero_flag` = 0 → `sel` = 0. bne with `zero_flag` = 0 → `sel` = 1.
- Opcode 1111111 → `illegal` = 1 and `pc_en` = 1 on cycle 2; `retired_cnt` unchanged; next cycle is FETCH.
- Store with `rst` asserted during MEM → `memw` falls in the same cycle; FETCH after release; with CNT_W = 2, four retired instructions wrap `retired_cnt` to 0.
